// File: rtl/audio_level_meter.sv
// Windowed peak meter: maps per-window sample peak to a level, LED bar and peak-hold.
// Optional LEVEL_SEG_EN adds a two-digit 7-seg readout of the level (seg/an, active-low).
module audio_level_meter #(
  parameter int unsigned SAMPLE_W     = 12,
  parameter int unsigned WINDOW       = 4000,
  parameter int unsigned NUM_LEVELS   = 16,
  parameter int unsigned HOLD_UPDATES = 4,
  parameter int unsigned OFFSET       = 2048
`ifdef LEVEL_SEG_EN
  , parameter int unsigned REFRESH_BITS = 17
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_en,
  input  logic [SAMPLE_W-1:0]           mic_in,
  input  logic                          mode,
  output logic [$clog2(NUM_LEVELS)-1:0] level,
  output logic [$clog2(NUM_LEVELS)-1:0] hold_level,
  output logic [NUM_LEVELS-1:0]         led,
  output logic                          level_valid
`ifdef LEVEL_SEG_EN
  , output logic [7:0]                  seg,
  output logic [3:0]                    an
`endif
);

  localparam int unsigned LVL_W   = $clog2(NUM_LEVELS);
  localparam int unsigned CNT_W   = $clog2(WINDOW);
  localparam int unsigned HCNT_W  = (HOLD_UPDATES < 1) ? 1 : $clog2(HOLD_UPDATES + 1);
  localparam int unsigned SH_RAW  = SAMPLE_W - LVL_W;
  localparam int unsigned SH_MAG  = SAMPLE_W - 1 - LVL_W;
  localparam int unsigned MAG_MAX = (2 ** (SAMPLE_W - 1)) - 1;

  typedef enum logic {
    ACCUM  = 1'b0,
    UPDATE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic                mode_q, mode_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LVL_W-1:0]    hold_q, hold_d;
  logic [NUM_LEVELS-1:0] led_q, led_d;

  logic [SAMPLE_W:0]   mic_x, off_x, mag, mag_sat;
  logic [SAMPLE_W-1:0] v_c, peak_c;
  logic [LVL_W-1:0]    level_c;
  logic [NUM_LEVELS-1:0] led_c;

  // Sample conditioning, window peak and level/bar mapping of the closing window.
  always_comb begin
    mic_x   = {1'b0, mic_in};
    off_x   = (SAMPLE_W + 1)'(OFFSET);
    mag     = (mic_x >= off_x) ? (mic_x - off_x) : (off_x - mic_x);
    mag_sat = (mag > (SAMPLE_W + 1)'(MAG_MAX)) ? (SAMPLE_W + 1)'(MAG_MAX) : mag;
    v_c     = mode_q ? SAMPLE_W'(mag_sat) : mic_in;
    peak_c  = (v_c > acc_q) ? v_c : acc_q;
    level_c = mode_q ? LVL_W'(peak_c >> SH_MAG) : LVL_W'(peak_c >> SH_RAW);
    led_c   = '0;
    for (int i = 0; i < int'(NUM_LEVELS) - 1; i++) begin
      led_c[i] = (int'(level_c) > i);
    end
    led_c[NUM_LEVELS-1] = (level_c == LVL_W'(NUM_LEVELS - 1));
  end

  // Next-state: a mode change discards the open window; the last sample closes it.
  always_comb begin
    state_d = ACCUM;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    mode_d  = mode;
    level_d = level_q;
    hold_d  = hold_q;
    led_d   = led_q;
    if (mode != mode_q) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_en) begin
      if (cnt_q == CNT_W'(WINDOW - 1)) begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = UPDATE;
        level_d = level_c;
        led_d   = led_c;
        if (level_c >= hold_q) begin
          hold_d = level_c;
          hcnt_d = '0;
        end else if (hcnt_q < HCNT_W'(HOLD_UPDATES)) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end else begin
          hold_d = hold_q - LVL_W'(1);
        end
      end else begin
        acc_d = peak_c;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      mode_q  <= 1'b0;
      level_q <= '0;
      hold_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      mode_q  <= mode_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
    end
  end

  assign level       = level_q;
  assign hold_level  = hold_q;
  assign led         = led_q;
  assign level_valid = (state_q == UPDATE);

`ifdef LEVEL_SEG_EN
  localparam int unsigned DW = LVL_W + 4;

  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [7:0]              seg_q, seg_d;
  logic [3:0]              an_q, an_d;
  logic [DW-1:0]           lvl_x;
  logic [3:0]              digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Refresh MSB alternates ones (right digit) and tens digit of the current level.
  always_comb begin
    refresh_d = refresh_q + REFRESH_BITS'(1);
    lvl_x     = DW'(level_q);
    if (refresh_q[REFRESH_BITS-1]) begin
      digit = 4'((lvl_x / DW'(10)) % DW'(10));
      an_d  = 4'b1101;
    end else begin
      digit = 4'(lvl_x % DW'(10));
      an_d  = 4'b1110;
    end
    seg_d = {1'b1, seg7(digit)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
      seg_q     <= 8'hC0;
      an_q      <= 4'b1110;
    end else begin
      refresh_q <= refresh_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
`endif

endmodule

// File: tb/tb_audio_level_meter.sv
// Scoreboard bench for audio_level_meter with WINDOW=4, HOLD_UPDATES=2.
module tb_audio_level_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic [11:0] mic_in;
  logic        mode;
  logic [3:0]  level;
  logic [3:0]  hold_level;
  logic [15:0] led;
  logic        level_valid;
`ifdef LEVEL_SEG_EN
  logic [7:0]  seg;
  logic [3:0]  an;
`endif

  audio_level_meter #(
    .SAMPLE_W(12), .WINDOW(4), .NUM_LEVELS(16), .HOLD_UPDATES(2), .OFFSET(2048)
`ifdef LEVEL_SEG_EN
    , .REFRESH_BITS(3)
`endif
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .mic_in(mic_in), .mode(mode),
    .level(level), .hold_level(hold_level), .led(led), .level_valid(level_valid)
`ifdef LEVEL_SEG_EN
    , .seg(seg), .an(an)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    int hold;
    int leds;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every level_valid pulse must match the oldest expected update.
  always @(negedge clk) begin
    exp_t e;
    if (level_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("upd_cycle", cyc, e.cyc);
        chk("upd_level", int'(level), e.lvl);
        chk("upd_hold", int'(hold_level), e.hold);
        chk("upd_led", int'(led), e.leds);
      end
    end
  end

  task automatic smp(input int v);
    sample_en = 1'b1;
    mic_in    = 12'(v);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_upd(input int l, input int h, input int leds);
    exp_t e;
    e.lvl  = l;
    e.hold = h;
    e.leds = leds;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic chk_out(input string name, input int l, input int h, input int leds);
    chk({name, "_level"}, int'(level), l);
    chk({name, "_hold"}, int'(hold_level), h);
    chk({name, "_led"}, int'(led), leds);
    chk({name, "_valid"}, int'(level_valid), 0);
  endtask

  initial begin
    reset     = 1'b1;
    sample_en = 1'b1;
    mic_in    = 12'd4000;
    mode      = 1'b0;

    // Reset held with strobes active: everything stays zero.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_out("reset", 0, 0, 0);
    end
    reset     = 1'b0;
    sample_en = 1'b0;

    // Mode 0 window, split by idle gaps; no pulse before the 4th strobe.
    smp(100); smp(3000); smp(500);
    idle(3);
    smp(200);
    expect_upd(11, 11, 16'h07FF);
    idle(3);
    chk_out("stable_a", 11, 11, 16'h07FF);

`ifdef LEVEL_SEG_EN
    begin
      int seen_ones = 0;
      int seen_tens = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (an == 4'b1110) seen_ones = 1;
        if (an == 4'b1101) seen_tens = 1;
        chk("seg_value", int'(seg), 8'hF9);
        chk("an_legal", int'(an == 4'b1110 || an == 4'b1101), 1);
      end
      chk("an_alternates", seen_ones + seen_tens, 2);
      #1;
    end
`endif

    // Mode 1 magnitude about the midpoint.
    mode = 1'b1;
    idle(2);
    smp(2048); smp(1000); smp(2100); smp(2048);
    expect_upd(8, 11, 16'h00FF);
    idle(2);
    smp(0); smp(2048); smp(2048); smp(2048);
    expect_upd(15, 15, 16'hFFFF);
    idle(2);
    chk_out("stable_c", 15, 15, 16'hFFFF);

    // Fresh start, then hold decay over silent windows (back-to-back strobes).
    mode  = 1'b0;
    reset = 1'b1;
    idle(2);
    chk_out("reset2", 0, 0, 0);
    reset = 1'b0;
    idle(1);
    smp(3000); smp(0); smp(0); smp(0);
    expect_upd(11, 11, 16'h07FF);
    smp(0); smp(0); smp(0); smp(0);
    expect_upd(0, 11, 0);
    smp(0); smp(0); smp(0); smp(0);
    expect_upd(0, 11, 0);
    smp(0); smp(0); smp(0); smp(0);
    expect_upd(0, 10, 0);
    smp(0); smp(0); smp(0); smp(0);
    expect_upd(0, 9, 0);
    idle(2);

    // Mode toggle aborts a half-filled window; hold decay stops at the level.
    smp(4000); smp(4000);
    idle(1);
    mode = 1'b1;
    idle(2);
    smp(2048); smp(2048); smp(2048); smp(1024);
    expect_upd(8, 8, 16'h00FF);
    idle(2);

    // Strobe in the UPDATE cycle opens the next window.
    smp(2048); smp(2048); smp(2048); smp(2348);
    expect_upd(2, 7, 16'h0003);
    smp(4000); smp(2048); smp(2048); smp(2048);
    expect_upd(15, 15, 16'hFFFF);
    idle(2);

    // Reset mid-window discards the partial window.
    mode = 1'b0;
    idle(2);
    smp(4000); smp(4000);
    reset = 1'b1;
    idle(1);
    chk_out("reset_mid", 0, 0, 0);
    reset = 1'b0;
    smp(500); smp(600); smp(700);
    idle(2);
    smp(256);
    expect_upd(2, 2, 16'h0003);
    idle(3);
    chk_out("stable_f", 2, 2, 16'h0003);

    chk("pending_updates", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
